// File: rtl/mul_seq.sv
// Multi-cycle shift-add sequencer for MUL/MULH/MULHSU/MULHU.
// Operands are converted to sign/magnitude on entry and the sign is restored in FIX.
module mul_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  mul_op,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        reg_we_out
);
  // Operation codes as assigned in core.svh.
  localparam logic [3:0] MUL_MUL    = 4'd1;
  localparam logic [3:0] MUL_MULH   = 4'd2;
  localparam logic [3:0] MUL_MULHSU = 4'd3;

  localparam int ITER = 32 / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [63:0]   acc, mcand;
  logic [31:0]   mplier;
  logic [CW-1:0] cnt;
  logic          neg, hi_sel;
  logic [4:0]    rd_q;

  logic          accept, sgn1, sgn2;
  logic [31:0]   a_mag, b_mag;
  logic [63:0]   acc_step, acc_fix;

  always_comb begin
    accept = (state == IDLE) && start && (mul_op != 4'd0) && !flush;
    sgn1   = (mul_op == MUL_MULH) || (mul_op == MUL_MULHSU);
    sgn2   = (mul_op == MUL_MULH);
    // 32-bit unsigned magnitude: 0x80000000 stays 0x80000000 (= 2^31)
    a_mag  = (sgn1 && rs1_val[31]) ? (32'd0 - rs1_val) : rs1_val;
    b_mag  = (sgn2 && rs2_val[31]) ? (32'd0 - rs2_val) : rs2_val;
    acc_step = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++)
      if (mplier[i]) acc_step = acc_step + (mcand << i);
    acc_fix = neg ? (64'd0 - acc) : acc;
  end

  assign stall      = reset_n && (accept || (!flush && (state == CALC || state == FIX)));
  assign reg_we_out = done && (rd_out != 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi_sel <= 1'b0;
      rd_q   <= '0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            mcand  <= {32'd0, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            neg    <= (sgn1 & rs1_val[31]) ^ (sgn2 & rs2_val[31]);
            hi_sel <= (mul_op != MUL_MUL);
            rd_q   <= rd_in;
            cnt    <= CW'(ITER - 1);
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_step;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          acc    <= acc_fix;
          result <= hi_sel ? acc_fix[63:32] : acc_fix[31:0];
          rd_out <= rd_q;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: three instances (1, 2, 4 bits per cycle) checked every cycle
// against a timestamp/arithmetic model, plus directed literal expectations.
module tb_mul_seq;
  localparam logic [3:0] MUL = 4'd1, MULH = 4'd2, MULHSU = 4'd3, MULHU = 4'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start[3], flush[3];
  logic [3:0]  op[3];
  logic [31:0] a[3], b[3];
  logic [4:0]  rd[3];
  logic        stall_o[3], done_o[3], we_o[3];
  logic [31:0] res_o[3];
  logic [4:0]  rdo[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mul_seq #(.BITS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .reset_n(rst_n), .start(start[g]), .mul_op(op[g]),
      .rs1_val(a[g]), .rs2_val(b[g]), .rd_in(rd[g]), .flush(flush[g]),
      .stall(stall_o[g]), .done(done_o[g]), .result(res_o[g]),
      .rd_out(rdo[g]), .reg_we_out(we_o[g]));
  end

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Reference product from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_mul(logic [3:0] o, logic [31:0] x, logic [31:0] y);
    longint sx, sy, uy;
    longint unsigned ux, uuy;
    logic [63:0] p;
    sx = $signed(x); sy = $signed(y);
    ux = {32'd0, x}; uuy = {32'd0, y}; uy = {32'd0, y};
    case (o)
      MULH:    p = sx * sy;
      MULHSU:  p = sx * uy;
      default: p = ux * uuy;
    endcase
    return (o == MUL) ? p[31:0] : p[63:32];
  endfunction

  // Model: an accepted op at cycle t0 shows done at t0+ITER+2; stall covers t0..t0+ITER+1.
  bit          act[3];
  int          t0[3];
  logic [31:0] pres[3], mres[3];
  logic [4:0]  prd[3], mrd[3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        act[k] = 0; mres[k] = '0; mrd[k] = '0;
        chk("rst_stall", k, stall_o[k], 0);
        chk("rst_done", k, done_o[k], 0);
        chk("rst_result", k, res_o[k], 0);
        chk("rst_rd", k, rdo[k], 0);
        chk("rst_we", k, we_o[k], 0);
      end else begin
        int it;
        bit acc_now, e_done, e_stall;
        it = 32 >> k;
        e_done  = act[k] && (cyc == t0[k] + it + 2);
        if (e_done) begin mres[k] = pres[k]; mrd[k] = prd[k]; end
        acc_now = !act[k] && start[k] && (op[k] != 4'd0) && !flush[k];
        e_stall = acc_now || (act[k] && !flush[k] && cyc <= t0[k] + it + 1);
        chk("stall", k, stall_o[k], e_stall);
        chk("done", k, done_o[k], e_done);
        chk("result", k, res_o[k], mres[k]);
        chk("rd_out", k, rdo[k], mrd[k]);
        chk("reg_we", k, we_o[k], e_done && (mrd[k] != 0));
        if (flush[k]) act[k] = 0;
        else if (acc_now) begin
          act[k] = 1; t0[k] = cyc;
          pres[k] = ref_mul(op[k], a[k], b[k]); prd[k] = rd[k];
        end else if (e_done) act[k] = 0;
      end
    end
  end

  function automatic int exp_lat(int k);
    return (k == 0) ? 34 : (k == 1) ? 18 : 10;
  endfunction

  // Present one op for one cycle and wait (bounded) for done.
  task automatic run_op(int k, logic [3:0] o, logic [31:0] x, logic [31:0] y, logic [4:0] r,
                        output int lat, output int stl, output logic wev);
    int tst;
    start[k] = 1; op[k] = o; a[k] = x; b[k] = y; rd[k] = r; tst = cyc;
    @(negedge clk); stl = int'(stall_o[k]);
    @(posedge clk); #1; start[k] = 0; op[k] = 4'd0;
    lat = -1; wev = 1'bx;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_o[k]) begin lat = cyc - tst; wev = we_o[k]; break; end
      if (stall_o[k]) stl++;
    end
    @(posedge clk); #1;
  endtask

  typedef struct { logic [3:0] o; logic [31:0] x, y; logic [4:0] r; logic [31:0] e; } vec_t;
  vec_t dir[6];

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, stl, n, d0, d1, fi, it;
    logic wev, w0, w1;
    bit seen;
    for (int k = 0; k < 3; k++) begin
      start[k] = 0; flush[k] = 0; op[k] = '0; a[k] = '0; b[k] = '0; rd[k] = '0;
    end
    dir[0] = '{MUL,    32'd7,          32'd6,          5'd3, 32'h0000_002A};
    dir[1] = '{MULH,   32'h8000_0000,  32'h8000_0000,  5'd1, 32'h4000_0000};
    dir[2] = '{MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2, 32'h0000_0000};
    dir[3] = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4, 32'hFFFF_FFFE};
    dir[4] = '{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6, 32'hFFFF_FFFF};
    dir[5] = '{MUL,    32'hFFFF_FFFF,  32'h0000_0003,  5'd9, 32'hFFFF_FFFD};
    for (int i = 0; i < 6; i++)
      chk("model_pin", i, ref_mul(dir[i].o, dir[i].x, dir[i].y), dir[i].e);

    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) begin
        run_op(k, dir[i].o, dir[i].x, dir[i].y, dir[i].r, lat, stl, wev);
        chk("dir_result", k, res_o[k], dir[i].e);
        chk("dir_rd", k, rdo[k], dir[i].r);
        if (i == 0) begin
          chk("dir_latency", k, lat, exp_lat(k));
          chk("dir_stall_cycles", k, stl, exp_lat(k));
          chk("dir_we", k, wev, 1);
        end
      end
    end

    // Flush mid-operation, then flush together with a start in IDLE.
    for (int k = 0; k < 3; k++) begin
      it = 32 >> k; fi = (it >= 16) ? 10 : 3; seen = 0;
      for (int i = 0; i < 90; i++) begin
        start[k] = (i == 0) || (i == 60); op[k] = start[k] ? MUL : 4'd0;
        a[k] = 32'd5; b[k] = 32'd5; rd[k] = 5'd7;
        flush[k] = (i == fi) || (i == 60);
        @(negedge clk);
        if (done_o[k]) seen = 1;
        if (i == fi || i == 60) chk("flush_stall", k, stall_o[k], 0);
        if (i == fi + 1) chk("flush_idle_stall", k, stall_o[k], 0);
        @(posedge clk); #1;
      end
      start[k] = 0; op[k] = '0; flush[k] = 0;
      chk("flush_no_done", k, seen, 0);
      chk("flush_result_kept", k, res_o[k], 32'hFFFF_FFFD);
      chk("flush_rd_kept", k, rdo[k], 5'd9);
    end

    // Back-to-back: second request held until accepted in IDLE after DONE.
    for (int k = 0; k < 3; k++) begin
      it = 32 >> k; n = 0; d0 = -1; d1 = -1; w0 = 1'bx; w1 = 1'bx;
      for (int i = 0; i < 2 * it + 12; i++) begin
        if (i == 0) begin start[k] = 1; op[k] = MUL; a[k] = 32'd11; b[k] = 32'd13; rd[k] = 5'd0; end
        else if (i <= it + 3) begin start[k] = 1; op[k] = MUL; a[k] = 32'd100; b[k] = 32'd200; rd[k] = 5'd5; end
        else begin start[k] = 0; op[k] = '0; end
        @(negedge clk);
        if (done_o[k]) begin
          if (n == 0) begin d0 = i; w0 = we_o[k]; end
          else if (n == 1) begin d1 = i; w1 = we_o[k]; end
          n++;
        end
        @(posedge clk); #1;
      end
      chk("b2b_count", k, n, 2);
      chk("b2b_spacing", k, d1 - d0, exp_lat(k) + 1);
      chk("b2b_we0", k, w0, 0);
      chk("b2b_we1", k, w1, 1);
      chk("b2b_result", k, res_o[k], 32'd20000);
    end

    // Random ops, covered cycle-by-cycle by the model.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 25; i++) begin
        logic [3:0] o; logic [31:0] x, y;
        o = 4'($urandom_range(1, 4)); x = pick(); y = pick();
        run_op(k, o, x, y, 5'($urandom_range(0, 31)), lat, stl, wev);
        chk("rand_result", k, res_o[k], ref_mul(o, x, y));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end

    // Asynchronous reset in the middle of an operation.
    start[0] = 1; op[0] = MULHU; a[0] = 32'h1234_5678; b[0] = 32'h9ABC_DEF0; rd[0] = 5'd12;
    @(posedge clk); #1; start[0] = 0; op[0] = '0;
    repeat (4) @(posedge clk);
    #3 rst_n = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_rst_done", k, done_o[k], 0);
      chk("async_rst_result", k, res_o[k], 0);
      chk("async_rst_rd", k, rdo[k], 0);
      chk("async_rst_stall", k, stall_o[k], 0);
    end
    @(negedge clk); #2 rst_n = 1;
    seen = 0;
    for (int i = 0; i < 45; i++) begin @(negedge clk); if (done_o[0]) seen = 1; end
    chk("async_rst_no_done", 0, seen, 0);
    @(posedge clk); #1;
    run_op(0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, lat, stl, wev);
    chk("post_rst_result", 0, res_o[0], 32'hFFFF_FFFE);
    chk("post_rst_latency", 0, lat, 34);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle sequencer for the M-extension multiply path (MUL, MULH, MULHSU, MULHU). It sits beside the ALU in the execute stage and accepts an operation code from the decoder's `mul_op` field plus both register operands. It conditions operand signs, iterates a shift-add multiply over a configurable number of cycles and applies the final sign correction. It then returns the selected 32-bit half with its destination register. While an operation is in flight it holds the pipeline through `stall`.

## Interface
- `BITS_PER_CYCLE`, default 1: multiplier bits retired per iteration; legal values are 1, 2 and 4. ITER = 32/BITS_PER_CYCLE.
- `clk`, input, 1: sole clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: execute stage presents a multiply this cycle.
- `mul_op`, input, 4: MUL_MUL / MUL_MULH / MUL_MULHSU / MUL_MULHU codes from core.svh; 4'd0 means no multiply.
- `rs1_val`, input, 32: multiplicand operand.
- `rs2_val`, input, 32: multiplier operand.
- `rd_in`, input, 5: destination register.
- `flush`, input, 1: kills any in-flight operation.
- `stall`, output, 1: hold the pipeline. Combinational.
- `done`, output, 1: one-cycle pulse; result is valid. Registered.
- `result`, output, 32: selected product half. Registered.
- `rd_out`, output, 5: destination register of the returned result. Registered.
- `reg_we_out`, output, 1: equals `done` when `rd_out` is not 0, otherwise 0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - A start is accepted when `start` is 1, `mul_op` is not 0 and `flush` is 0.
  - On acceptance the block latches the operands, op and rd, and moves to CALC.
  - A start with `mul_op` = 0 is ignored.
- Operand conditioning happens at acceptance:
  - rs1 is treated as signed for MULH and MULHSU.
  - rs2 is treated as signed for MULH only.
  - MUL and MULHU treat both operands as unsigned; the low word is identical either way.
  - Signed operands are replaced by their absolute value, using 32-bit unsigned magnitude so that 0x80000000 maps to 2^31.
  - `neg` = sign(rs1) XOR sign(rs2), considering only the operands treated as signed.
- CALC:
  - Runs ITER cycles using a 64-bit accumulator, the multiplicand shifted left and the multiplier shifted right.
  - Each cycle adds `multiplicand × (low BITS_PER_CYCLE bits of the multiplier)` to the accumulator, then shifts both operands.
  - An iteration counter, width log2(ITER)+1, counts ITER-1 down to 0; the block goes to FIX after the count reaches 0.
- FIX:
  - If `neg` is set, the accumulator becomes its 64-bit two's complement.
  - `result` is loaded with bits [31:0] for MUL and bits [63:32] for the other ops.
  - `rd_out` is loaded with the latched rd.
- DONE:
  - `done` is 1 for exactly this one cycle.
  - The block returns to IDLE on the next edge.
- `result` and `rd_out` keep their values until the next FIX.
- `stall` = (state == IDLE && accepted start) || state == CALC || state == FIX. It is 0 in DONE so the pipeline advances and captures the result.
- Flush:
  - From any state, the block returns to IDLE on the next edge.
  - `done` is not raised and `result` is not updated.
  - `stall` is forced to 0 in the flush cycle.
  - `flush` together with `start` in IDLE means the start is not accepted.
- A start arriving in CALC or FIX is ignored; the pipeline is stalled, so it is re-presented.
- A start arriving in DONE is ignored. The pipeline re-presents the next instruction, which is accepted in IDLE one cycle later.

## Timing
- Reset values:
  - state IDLE
  - `done` 0, `result` 0, `rd_out` 0, `reg_we_out` 0
  - `stall` 0
  - internal accumulator, operands and counter 0
- Reset is asynchronous and may assert mid-operation: everything clears immediately and no `done` is produced.
- For a start accepted in cycle T:
  - CALC occupies T+1 .. T+ITER.
  - FIX occupies T+ITER+1.
  - `done` is high in T+ITER+2.
- Latency is therefore 34 cycles for BPC=1, 18 for BPC=2 and 10 for BPC=4.
- Issue interval is ITER+3 cycles back-to-back.
- `stall` is high from T through T+ITER+1, which is ITER+2 cycles.

## Test plan
- MUL 7 × 6, BPC=1, start at T -> `done` at T+34 with `result` 0x0000002A, `rd_out` equal to `rd_in`, `reg_we_out` 1, and `stall` high for exactly 34 cycles.
- MULH 0x80000000 × 0x80000000 -> `result` 0x40000000. MULH 0xFFFFFFFF × 0xFFFFFFFF -> `result` 0x00000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MUL 0xFFFFFFFF × 0x00000003 -> 0xFFFFFFFD.
- Assert `flush` at T+10 -> IDLE at T+11, no `done`, `result` unchanged. Assert `reset_n`=0 at T+5 -> all outputs 0 immediately.
- Back-to-back MUL ops with rd=0 and rd=5 -> two `done` pulses 35 cycles apart; `reg_we_out` is 0 for the first and 1 for the second.
- Repeat the first and third scenarios with BPC=2 and BPC=4 -> same results, with `done` at T+18 and T+10.
